// File: rtl/b1_uart_tx_fifo_if.sv
// Write-side handshake and status/serial outputs of the B1 report UART transmitter.
interface b1_uart_tx_fifo_if #(
    parameter int FIFO_AW = 6
);
    logic               wr_en;
    logic [7:0]         din;
    logic               full;
    logic [FIFO_AW:0]   level;
    logic               busy;
    logic               overflow;
    logic               tx;

    modport master (output wr_en, din, input full, level, busy, overflow, tx);
    modport slave  (input wr_en, din, output full, level, busy, overflow, tx);
endinterface

// File: rtl/b1_uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 LSB-first serialiser for the B1 observation report stream.
// Frames are emitted back-to-back while bytes remain buffered.
module b1_uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 668,
    parameter int FIFO_AW      = 6
) (
    input  logic              clk,
    input  logic              rst,
    b1_uart_tx_fifo_if.slave  bus
);
    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam int               CW       = $clog2(CLKS_PER_BIT);
    localparam logic [FIFO_AW:0] DEPTH_L  = (FIFO_AW+1)'(DEPTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wptr_r, rptr_r;
    logic [FIFO_AW:0]   level_r, level_nx_s;
    logic               full_r, overflow_r;
    logic               wr_ok_s, pop_s;

    state_t             state_r, state_nx_s;
    logic [CW-1:0]      cnt_r, cnt_nx_s;
    logic [2:0]         bit_r, bit_nx_s;
    logic [7:0]         shift_r, shift_nx_s;
    logic               tx_r, tx_nx_s;
    logic               busy_r;

    // full is the registered flag, so a write racing a pop from a full FIFO is still rejected
    assign wr_ok_s = bus.wr_en && !full_r;

    // Next FIFO occupancy from accepted write and serialiser pop
    always_comb begin
        level_nx_s = level_r;
        case ({wr_ok_s, pop_s})
            2'b10:   level_nx_s = level_r + (FIFO_AW+1)'(1);
            2'b01:   level_nx_s = level_r - (FIFO_AW+1)'(1);
            default: level_nx_s = level_r;
        endcase
    end

    // FIFO storage, written without reset
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wptr_r] <= bus.din;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r     <= '0;
            rptr_r     <= '0;
            level_r    <= '0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wptr_r <= wptr_r + FIFO_AW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + FIFO_AW'(1);
            end
            level_r <= level_nx_s;
            full_r  <= (level_nx_s == DEPTH_L);
            if (bus.wr_en && full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Serialiser next state, bit timer, shift register and pop request
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r + CW'(1);
        bit_nx_s   = bit_r;
        shift_nx_s = shift_r;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nx_s = '0;
                if (level_r != '0) begin
                    pop_s      = 1'b1;
                    shift_nx_s = mem_r[rptr_r];
                    state_nx_s = START;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nx_s   = '0;
                    bit_nx_s   = 3'd0;
                    state_nx_s = DATA;
                end else begin
                    state_nx_s = START;
                end
            end
            DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nx_s   = '0;
                    shift_nx_s = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_nx_s = STOP;
                    end else begin
                        bit_nx_s = bit_r + 3'd1;
                    end
                end else begin
                    state_nx_s = DATA;
                end
            end
            STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nx_s = '0;
                    // chain straight into the next start bit when more data is waiting
                    if (level_r != '0) begin
                        pop_s      = 1'b1;
                        shift_nx_s = mem_r[rptr_r];
                        state_nx_s = START;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else begin
                    state_nx_s = STOP;
                end
            end
            default: begin
                cnt_nx_s   = '0;
                state_nx_s = IDLE;
            end
        endcase

        case (state_nx_s)
            START:   tx_nx_s = 1'b0;
            DATA:    tx_nx_s = shift_nx_s[0];
            default: tx_nx_s = 1'b1;
        endcase
    end

    // Serialiser state register with flopped line and busy outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            bit_r   <= bit_nx_s;
            shift_r <= shift_nx_s;
            tx_r    <= tx_nx_s;
            busy_r  <= (state_nx_s != IDLE);
        end
    end

    assign bus.full     = full_r;
    assign bus.level    = level_r;
    assign bus.busy     = busy_r;
    assign bus.overflow = overflow_r;
    assign bus.tx       = tx_r;

endmodule
